// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//   Stopwatch core (hour:minute:second.fraction) with a first-word-fall-through
//   lap-capture FIFO.
// Ports
//   clock, reset          : clock; asynchronous active-high reset
//   run                   : level, 1 = count, 0 = pause (prescaler holds)
//   clear                 : pulse, zero time counters, prescaler and wrapped
//   lap / lap_pop         : pulse, push current time / discard FIFO head
//   lap_flush             : pulse, empty FIFO and clear lap_ovf
//   hour/minute/second    : current time (6b each)
//   m_sec                 : current fraction 0..TICK_HZ-1 (7b)
//   wrapped               : sticky, hour wrapped HOURS-1 -> 0
//   lap_valid/lap_time    : FIFO non-empty / head {h,m,s,f}, 0 when empty
//   lap_count/lap_full    : entries held / count == LAP_DEPTH
//   lap_ovf               : sticky, a lap was dropped on a full FIFO
module lap_stopwatch #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOURS     = 24,
  parameter int LAP_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        lap,
  input  logic        lap_pop,
  input  logic        lap_flush,
  output logic [5:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic [6:0]  m_sec,
  output logic        wrapped,
  output logic        lap_valid,
  output logic [24:0] lap_time,
  output logic [6:0]  lap_count,
  output logic        lap_full,
  output logic        lap_ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(LAP_DEPTH);

  localparam logic [PW-1:0] PS_TERM = PW'(DIV - 1);
  localparam logic [6:0]    FR_TERM = 7'(TICK_HZ - 1);
  localparam logic [5:0]    HR_TERM = 6'(HOURS - 1);
  localparam logic [6:0]    DEPTH   = 7'(LAP_DEPTH);

  // ---------------- time counters ----------------
  logic [PW-1:0] ps_q, ps_d;
  logic [6:0]    fr_q, fr_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  assign tick = run && (ps_q == PS_TERM);

  always_comb begin
    ps_d   = ps_q;
    fr_d   = fr_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    wrap_d = wrap_q;
    // Prescaler only advances while running, so a pause keeps the partial tick.
    if (run) ps_d = tick ? '0 : ps_q + 1'b1;
    if (tick) begin
      if (fr_q == FR_TERM) begin
        fr_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            if (hr_q == HR_TERM) begin
              hr_d   = '0;
              wrap_d = 1'b1;
            end else begin
              hr_d = hr_q + 1'b1;
            end
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end else begin
        fr_d = fr_q + 1'b1;
      end
    end
    // clear overrides any same-cycle tick.
    if (clear) begin
      ps_d   = '0;
      fr_d   = '0;
      sec_d  = '0;
      min_d  = '0;
      hr_d   = '0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      fr_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      fr_q   <= fr_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      wrap_q <= wrap_d;
    end
  end

  // ---------------- lap FIFO ----------------
  logic [24:0]   mem [LAP_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          full_q, full_d, valid_q, valid_d, ovf_q, ovf_d;
  logic          do_push, do_pop;
  logic [24:0]   cur_time;

  // Captured value is the time registered before this edge (pre-tick, pre-clear).
  assign cur_time = {hr_q, min_q, sec_q, fr_q};

  // A pop frees a slot in the same cycle, so lap+pop on a full FIFO both happen.
  assign do_pop  = lap_pop && valid_q && !lap_flush;
  assign do_push = lap && !lap_flush && (!full_q || do_pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (lap_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
      if (lap && !do_push) ovf_d = 1'b1;
    end
    full_d  = (cnt_d == DEPTH);
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: every read is gated by valid_q.
  always_ff @(posedge clock) begin
    if (do_push) mem[wp_q] <= cur_time;
  end

  assign hour      = hr_q;
  assign minute    = min_q;
  assign second    = sec_q;
  assign m_sec     = fr_q;
  assign wrapped   = wrap_q;
  assign lap_valid = valid_q;
  assign lap_time  = valid_q ? mem[rp_q] : '0;
  assign lap_count = cnt_q;
  assign lap_full  = full_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;

  logic clock, reset, run, clear, lap, lap_pop, lap_flush;
  logic [5:0]  hour, minute, second;
  logic [6:0]  m_sec, lap_count;
  logic        wrapped, lap_valid, lap_full, lap_ovf;
  logic [24:0] lap_time;

  // Second instance with a fast time base so a full hour wrap fits the run.
  logic w_run, w_clear;
  logic [5:0]  w_hour, w_minute, w_second;
  logic [6:0]  w_m_sec, w_lap_count;
  logic        w_wrapped, w_lap_valid, w_lap_full, w_lap_ovf;
  logic [24:0] w_lap_time;

  int n_assert = 0;
  int n_fail   = 0;

  lap_stopwatch #(.CLK_HZ(200), .TICK_HZ(100), .HOURS(2), .LAP_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .run(run), .clear(clear), .lap(lap),
    .lap_pop(lap_pop), .lap_flush(lap_flush),
    .hour(hour), .minute(minute), .second(second), .m_sec(m_sec),
    .wrapped(wrapped), .lap_valid(lap_valid), .lap_time(lap_time),
    .lap_count(lap_count), .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  lap_stopwatch #(.CLK_HZ(4), .TICK_HZ(2), .HOURS(2), .LAP_DEPTH(4)) dut_w (
    .clock(clock), .reset(reset), .run(w_run), .clear(w_clear), .lap(1'b0),
    .lap_pop(1'b0), .lap_flush(1'b0),
    .hour(w_hour), .minute(w_minute), .second(w_second), .m_sec(w_m_sec),
    .wrapped(w_wrapped), .lap_valid(w_lap_valid), .lap_time(w_lap_time),
    .lap_count(w_lap_count), .lap_full(w_lap_full), .lap_ovf(w_lap_ovf)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [5:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic [6:0] f,
                          input int eh, input int em, input int es, input int ef);
    chk({tag, ".hour"},   32'(h), 32'(eh));
    chk({tag, ".minute"}, 32'(m), 32'(em));
    chk({tag, ".second"}, 32'(s), 32'(es));
    chk({tag, ".m_sec"},  32'(f), 32'(ef));
  endtask

  function automatic logic [31:0] tp(input int h, input int m, input int s, input int f);
    logic [24:0] t;
    t = {6'(h), 6'(m), 6'(s), 7'(f)};
    return 32'(t);
  endfunction

  task automatic pulse_lap();
    lap = 1; step(1); lap = 0;
  endtask

  task automatic pulse_pop();
    lap_pop = 1; step(1); lap_pop = 0;
  endtask

  initial begin
    clock = 0; reset = 1; run = 0; clear = 0; lap = 0; lap_pop = 0; lap_flush = 0;
    w_run = 0; w_clear = 0;

    // 1. reset state, async reset mid-count, restart
    step(2);
    chk_time("rst", hour, minute, second, m_sec, 0, 0, 0, 0);
    chk("rst.flags", 32'({wrapped, lap_valid, lap_full, lap_ovf}), 0);
    chk("rst.lap_count", 32'(lap_count), 0);
    chk("rst.lap_time", 32'(lap_time), 0);
    reset = 0; run = 1;
    step(7);
    chk_time("t1.run7", hour, minute, second, m_sec, 0, 0, 0, 3);
    pulse_lap();
    chk("t1.lap_valid", 32'(lap_valid), 1);
    #2 reset = 1;
    #1;
    chk_time("t1.async", hour, minute, second, m_sec, 0, 0, 0, 0);
    chk("t1.async.lap_valid", 32'(lap_valid), 0);
    chk("t1.async.lap_count", 32'(lap_count), 0);
    chk("t1.async.lap_time", 32'(lap_time), 0);
    run = 0;
    step(1);
    reset = 0; run = 1;
    step(2);
    chk_time("t1.restart", hour, minute, second, m_sec, 0, 0, 0, 1);

    // 2. prescaler and pause behaviour
    run = 0; clear = 1; step(1); clear = 0;
    chk_time("t2.clear", hour, minute, second, m_sec, 0, 0, 0, 0);
    run = 1; step(200);
    chk_time("t2.200", hour, minute, second, m_sec, 0, 0, 1, 0);
    step(1);
    chk_time("t2.201", hour, minute, second, m_sec, 0, 0, 1, 0);
    run = 0; step(50);
    chk_time("t2.paused", hour, minute, second, m_sec, 0, 0, 1, 0);
    run = 1; step(1);
    chk_time("t2.resume", hour, minute, second, m_sec, 0, 0, 1, 1);
    run = 0;

    // 4. five laps into a 4-deep FIFO, then drain
    pulse_lap();
    chk("t4.count1", 32'(lap_count), 1);
    chk("t4.head1", 32'(lap_time), tp(0, 0, 1, 1));
    run = 1; step(20); run = 0;
    pulse_lap();
    run = 1; step(200); run = 0;
    pulse_lap();
    run = 1; step(60); run = 0;
    chk_time("t4.time", hour, minute, second, m_sec, 0, 0, 2, 41);
    pulse_lap();
    chk("t4.count4", 32'(lap_count), 4);
    chk("t4.full", 32'(lap_full), 1);
    chk("t4.ovf0", 32'(lap_ovf), 0);
    run = 1; step(2); run = 0;
    pulse_lap();
    chk("t4.count_drop", 32'(lap_count), 4);
    chk("t4.ovf1", 32'(lap_ovf), 1);
    chk("t4.head_drop", 32'(lap_time), tp(0, 0, 1, 1));
    pulse_pop();
    chk("t4.pop1.head", 32'(lap_time), tp(0, 0, 1, 11));
    chk("t4.pop1.count", 32'(lap_count), 3);
    chk("t4.pop1.full", 32'(lap_full), 0);
    pulse_pop();
    chk("t4.pop2.head", 32'(lap_time), tp(0, 0, 2, 11));
    pulse_pop();
    chk("t4.pop3.head", 32'(lap_time), tp(0, 0, 2, 41));
    chk("t4.pop3.count", 32'(lap_count), 1);
    pulse_pop();
    chk("t4.pop4.valid", 32'(lap_valid), 0);
    chk("t4.pop4.time", 32'(lap_time), 0);
    chk("t4.pop4.count", 32'(lap_count), 0);
    chk("t4.pop4.ovf", 32'(lap_ovf), 1);
    pulse_pop();
    chk("t4.pop_empty.count", 32'(lap_count), 0);

    // 6. full FIFO: lap+pop, lap overflow, lap+flush
    lap_flush = 1; step(1); lap_flush = 0;
    chk("t6.flush.ovf", 32'(lap_ovf), 0);
    chk("t6.flush.count", 32'(lap_count), 0);
    pulse_lap();
    run = 1; step(2); run = 0;
    pulse_lap(); pulse_lap(); pulse_lap();
    chk("t6.fill.count", 32'(lap_count), 4);
    chk("t6.fill.head", 32'(lap_time), tp(0, 0, 2, 42));
    lap = 1; lap_pop = 1; step(1); lap = 0; lap_pop = 0;
    chk("t6.lappop.count", 32'(lap_count), 4);
    chk("t6.lappop.full", 32'(lap_full), 1);
    chk("t6.lappop.ovf", 32'(lap_ovf), 0);
    chk("t6.lappop.head", 32'(lap_time), tp(0, 0, 2, 43));
    pulse_lap();
    chk("t6.over.ovf", 32'(lap_ovf), 1);
    lap = 1; lap_flush = 1; step(1); lap = 0; lap_flush = 0;
    chk("t6.lapflush.count", 32'(lap_count), 0);
    chk("t6.lapflush.ovf", 32'(lap_ovf), 0);
    chk("t6.lapflush.flags", 32'({lap_valid, lap_full}), 0);
    chk("t6.lapflush.time", 32'(lap_time), 0);

    // 5. lap + clear + tick in the same cycle
    run = 1; step(196);
    chk_time("t5.pre0", hour, minute, second, m_sec, 0, 0, 3, 41);
    step(1);
    chk_time("t5.pre1", hour, minute, second, m_sec, 0, 0, 3, 41);
    lap = 1; clear = 1; step(1); lap = 0; clear = 0; run = 0;
    chk_time("t5.disp", hour, minute, second, m_sec, 0, 0, 0, 0);
    chk("t5.head", 32'(lap_time), tp(0, 0, 3, 41));
    chk("t5.count", 32'(lap_count), 1);
    chk("t5.wrapped", 32'(wrapped), 0);

    // 3. hour wrap (fast instance: one tick every 2 clocks, 2 ticks per second)
    w_run = 1; step(28798);
    chk_time("t3.pre", w_hour, w_minute, w_second, w_m_sec, 1, 59, 59, 1);
    chk("t3.pre.wrapped", 32'(w_wrapped), 0);
    step(2);
    chk_time("t3.wrap", w_hour, w_minute, w_second, w_m_sec, 0, 0, 0, 0);
    chk("t3.wrapped", 32'(w_wrapped), 1);
    w_run = 0; w_clear = 1; step(1); w_clear = 0;
    chk("t3.clear.wrapped", 32'(w_wrapped), 0);
    chk("t3.fifo_idle", 32'({w_lap_valid, w_lap_full, w_lap_ovf, w_lap_count}), 0);
    chk("t3.fifo_time", 32'(w_lap_time), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
